// File: rtl/cpu_common.sv
// cpu_common: shared types for the vgacpu core.
// Holds the ALU opcode enumeration. ALU_SL is encoded as zero, so a
// cleared decode slot is also a valid "no ALU operation" slot.
package cpu_common;

  typedef enum logic [2:0] {
    ALU_SL  = 3'd0,
    ALU_SR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_MUL = 3'd7
  } alu_operation_t;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshakes of the decode stage.
//   flush                 : synchronous discard of everything in the stage
//   in_valid/in_ready     : fetch -> decode handshake, payload in_inst
//   out_valid/out_ready   : decode -> execute handshake
//   immediate, inst_type, rf_we, rf_write_addr, rx_re, rX_addr,
//   alu_en, alu_operation : decoded slot contents
// Modports: master = the side driving fetch data and execute ready,
//           slave  = the decode stage itself.
interface decode_stage_if #(
  parameter int IMM_W = 8
);
  localparam int INST_W = IMM_W + 8;

  logic                         flush;
  logic                         in_valid;
  logic [INST_W-1:0]            in_inst;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [IMM_W-1:0]             immediate;
  logic [1:0]                   inst_type;
  logic                         rf_we;
  logic [2:0]                   rf_write_addr;
  logic                         rx_re;
  logic [2:0]                   rX_addr;
  logic                         alu_en;
  cpu_common::alu_operation_t   alu_operation;

  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, immediate, inst_type, rf_we, rf_write_addr,
           rx_re, rX_addr, alu_en, alu_operation
  );

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, immediate, inst_type, rf_we, rf_write_addr,
           rx_re, rX_addr, alu_en, alu_operation
  );

endinterface

// File: rtl/decode_stage.sv
// decode_stage: elastic instruction-decode stage of the vgacpu core.
// Raw instructions from fetch are buffered in a DEPTH-entry FIFO; the FIFO
// head is decoded and registered into a single output slot for execute.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (drops everything in flight)
//   bus  : decode_stage_if.slave (fetch handshake, execute handshake, flush,
//          decoded fields)
// in_ready is purely a function of the FIFO count, so there is no
// combinational path from out_ready to in_ready.
module decode_stage #(
  parameter int IMM_W = 8,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  decode_stage_if.slave   bus
);
  import cpu_common::*;

  localparam int INST_W = IMM_W + 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic           rf_we;
    logic [2:0]     rf_wa;
    logic           rx_re;
    logic [2:0]     rx_a;
    logic           alu_en;
    alu_operation_t alu_op;
  } dec_t;

  // Register-access decode of the low 11 instruction bits.
  // Everything not explicitly enabled stays zero.
  function automatic dec_t decode_fn(input logic [10:0] i);
    dec_t       d;
    logic [2:0] r;
    logic [2:0] s;
    logic [2:0] x;
    d = '0;
    r = i[7:5];
    s = i[4:2];
    x = i[10:8];
    case (i[1:0])
      2'b01: begin
        case (s)
          3'b000: begin
            d.rx_re = 1'b1;
            d.rx_a  = r;
          end
          3'b001: begin
            d.rf_we = 1'b1;
            d.rf_wa = r;
          end
          default: begin
            // ALU ops write the accumulator r0 and read rX = r.
            d.alu_en = 1'b1;
            d.rf_we  = 1'b1;
            d.rx_re  = 1'b1;
            d.rx_a   = r;
            case (s)
              3'b010:  d.alu_op = ALU_ADD;
              3'b011:  d.alu_op = ALU_SUB;
              3'b100:  d.alu_op = ALU_AND;
              3'b101:  d.alu_op = ALU_OR;
              3'b110:  d.alu_op = ALU_XOR;
              default: d.alu_op = ALU_MUL;
            endcase
          end
        endcase
      end
      2'b10: begin
        d.rf_we = 1'b1;
        d.rf_wa = r;
        d.rx_re = 1'b1;
        d.rx_a  = r;
      end
      2'b11: begin
        case (i[7:2])
          6'b100000: begin
            d.rf_we = 1'b1;
            d.rf_wa = x;
            d.rx_re = 1'b1;
          end
          6'b100001: begin
            d.rf_we = 1'b1;
            d.rx_re = 1'b1;
            d.rx_a  = x;
          end
          6'b110000, 6'b110001: begin
            d.alu_en = 1'b1;
            d.alu_op = i[2] ? ALU_SR : ALU_SL;
            d.rf_we  = 1'b1;
            d.rx_re  = 1'b1;
          end
          default: d = '0;
        endcase
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  logic [INST_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_out_valid_p1;
  logic [IMM_W-1:0]  r_imm_p1;
  logic [1:0]        r_type_p1;
  dec_t              r_dec_p1;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [INST_W-1:0] w_head_p0;
  dec_t              w_dec_p0;

  assign w_in_ready = (r_count != CNT_W'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop      = (r_count != '0) && (!r_out_valid_p1 || bus.out_ready) && !bus.flush;

  // ---- stage p0: FIFO storage and head decode ----
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_inst;
    end
  end

  assign w_head_p0 = r_mem[r_rd_ptr];
  assign w_dec_p0  = decode_fn(w_head_p0[10:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---- stage p1: registered output slot ----
  // Flush only invalidates the slot; the decoded fields keep their value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid_p1 <= 1'b0;
      r_imm_p1       <= '0;
      r_type_p1      <= '0;
      r_dec_p1       <= '0;
    end else if (bus.flush) begin
      r_out_valid_p1 <= 1'b0;
    end else if (w_pop) begin
      r_out_valid_p1 <= 1'b1;
      r_imm_p1       <= w_head_p0[INST_W-1:8];
      r_type_p1      <= w_head_p0[1:0];
      r_dec_p1       <= w_dec_p0;
    end else if (bus.out_ready) begin
      r_out_valid_p1 <= 1'b0;
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_out_valid_p1;
  assign bus.immediate     = r_imm_p1;
  assign bus.inst_type     = r_type_p1;
  assign bus.rf_we         = r_dec_p1.rf_we;
  assign bus.rf_write_addr = r_dec_p1.rf_wa;
  assign bus.rx_re         = r_dec_p1.rx_re;
  assign bus.rX_addr       = r_dec_p1.rx_a;
  assign bus.alu_en        = r_dec_p1.alu_en;
  assign bus.alu_operation = r_dec_p1.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage with a queue-level
// reference model and a per-cycle compare process.
module tb_decode_stage;
  localparam int IMM_W = 8;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [7:0] imm;
    logic [1:0] ty;
    logic       we;
    logic [2:0] wa;
    logic       re;
    logic [2:0] ra;
    logic       en;
    logic [2:0] op;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   started  = 0;

  decode_stage_if #(.IMM_W(IMM_W)) bus ();

  decode_stage #(.IMM_W(IMM_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] op_of(input logic [2:0] s);
    case (s)
      3'd2:    return cpu_common::ALU_ADD;
      3'd3:    return cpu_common::ALU_SUB;
      3'd4:    return cpu_common::ALU_AND;
      3'd5:    return cpu_common::ALU_OR;
      3'd6:    return cpu_common::ALU_XOR;
      default: return cpu_common::ALU_MUL;
    endcase
  endfunction

  // What execute must see for a given raw instruction.
  function automatic exp_t model_decode(input logic [15:0] v);
    exp_t       e;
    logic [2:0] r;
    logic [2:0] s;
    logic [2:0] x;
    e    = '0;
    e.imm = v[15:8];
    e.ty  = v[1:0];
    r = v[7:5];
    s = v[4:2];
    x = v[10:8];
    if (v[1:0] == 2'b01 && s == 3'd0) begin
      e.re = 1'b1; e.ra = r;
    end else if (v[1:0] == 2'b01 && s == 3'd1) begin
      e.we = 1'b1; e.wa = r;
    end else if (v[1:0] == 2'b01) begin
      e.en = 1'b1; e.op = op_of(s); e.we = 1'b1; e.re = 1'b1; e.ra = r;
    end else if (v[1:0] == 2'b10) begin
      e.we = 1'b1; e.wa = r; e.re = 1'b1; e.ra = r;
    end else if (v[1:0] == 2'b11) begin
      if (v[7:2] == 6'h20) begin
        e.we = 1'b1; e.wa = x; e.re = 1'b1;
      end else if (v[7:2] == 6'h21) begin
        e.we = 1'b1; e.re = 1'b1; e.ra = x;
      end else if (v[7:2] == 6'h30 || v[7:2] == 6'h31) begin
        e.en = 1'b1; e.we = 1'b1; e.re = 1'b1;
        e.op = v[2] ? 3'(cpu_common::ALU_SR) : 3'(cpu_common::ALU_SL);
      end
    end
    return e;
  endfunction

  // Reference model: a FIFO queue plus one presented slot.
  logic [15:0] mq[$];
  logic        mv;
  exp_t        me;
  bit          m_rdy, m_take, m_push;
  logic [15:0] m_head;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mv = 1'b0;
      me = '0;
    end else if (bus.flush) begin
      mq.delete();
      mv = 1'b0;
    end else begin
      m_rdy  = (mq.size() != DEPTH);
      m_take = (mq.size() != 0) && (!mv || bus.out_ready);
      m_push = bus.in_valid && m_rdy;
      if (m_take) begin
        m_head = mq.pop_front();
        me = model_decode(m_head);
        mv = 1'b1;
      end else if (bus.out_ready) begin
        mv = 1'b0;
      end
      if (m_push) mq.push_back(bus.in_inst);
    end
  end

  function automatic logic [31:0] dut_fields();
    return 32'({bus.immediate, bus.inst_type, bus.rf_we, bus.rf_write_addr,
                bus.rx_re, bus.rX_addr, bus.alu_en, 3'(bus.alu_operation)});
  endfunction

  logic [7:0] seen[$];

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != DEPTH));
      chk("out_valid", 32'(bus.out_valid), 32'(mv));
      chk("fields", dut_fields(), 32'(me));
      if (bus.out_valid && bus.out_ready) seen.push_back(bus.immediate);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = v;
    while (!acc && n < 50) begin
      acc = bus.in_ready;
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL push_timeout: instruction %0h not accepted within 50 cycles", v);
    end
  endtask

  task automatic chk_slot(input string name, input logic [31:0] exp);
    chk(name, dut_fields(), exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   idx;
    int   cyc;
    logic rdy;
    logic [7:0] low_tab [8];
    low_tab = '{8'h49, 8'h21, 8'h3D, 8'hE6, 8'h83, 8'h87, 8'hC3, 8'hC7};

    rst = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst = '0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 started = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk_slot("reset_fields", 32'd0);

    // ADD r2: visible one edge after the push edge.
    bus.out_ready = 1'b1;
    push(16'h1249);
    chk("latency_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    // imm 12, type 01, we 1 wa 0, re 1 ra 2, en 1, op ADD(2)
    chk_slot("add_fields", 32'({8'h12, 2'b01, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 3'd2}));

    // 0TOX then XTO0 back to back.
    push(16'h0583);
    push(16'h0587);
    chk_slot("0tox_fields", 32'({8'h05, 2'b11, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0}));
    step();
    chk_slot("xto0_fields", 32'({8'h05, 2'b11, 1'b1, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0}));
    repeat (3) step();

    // Backpressure with DEPTH=2.
    seen.delete();
    bus.out_ready = 1'b0;
    push(16'h1100);
    push(16'h2221);
    push(16'h33E6);
    bus.in_valid = 1'b1;
    bus.in_inst  = 16'h44C3;
    step();
    step();
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_slot_imm", 32'(bus.immediate), 32'h11);
    bus.out_ready = 1'b1;
    push(16'h44C3);
    repeat (5) step();
    chk("bp_count", 32'(seen.size()), 32'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      chk("bp_order", 32'(seen[k]), 32'(8'h11 * (k + 1)));
    end

    // Wrap-around stream of 20 with out_ready toggling.
    seen.delete();
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < 200) begin
      bus.in_valid  = 1'b1;
      bus.in_inst   = {8'(8'h50 + idx), low_tab[idx % 8]};
      bus.out_ready = (cyc % 2 == 0);
      rdy = bus.in_ready;
      step();
      if (rdy) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) step();
    chk("wrap_count", 32'(seen.size()), 32'd20);
    for (int k = 0; k < 20 && k < seen.size(); k++) begin
      chk("wrap_order", 32'(seen[k]), 32'(8'h50 + k));
    end

    // Flush with FIFO full and slot valid, input offered.
    seen.delete();
    bus.out_ready = 1'b0;
    push(16'h6149);
    push(16'h624D);
    push(16'h6351);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid  = 1'b1;
    bus.in_inst   = 16'h7749;
    bus.flush     = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_fields_kept", 32'(bus.immediate), 32'h61);
    // Flush while in_ready=1: offered word must still be dropped.
    bus.in_valid  = 1'b1;
    bus.in_inst   = 16'h7849;
    bus.flush     = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk("flush_nothing_out", 32'(seen.size()), 32'd0);
    chk("flush_still_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-stream.
    bus.out_ready = 1'b0;
    push(16'h1249);
    step();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_fields", dut_fields(), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
